// File: rtl/heroe_pkg.sv
// Shared definitions for the HEROE game: state codes, win/lose codes and default timing.
package heroe_pkg;

    typedef enum logic [2:0] {
        OFF  = 3'd0,
        WLCM = 3'd1,
        CH   = 3'd2,
        GAME = 3'd3,
        WL   = 3'd4,
        PA   = 3'd5
    } estado_t;

    localparam logic [1:0] JUGANDO = 2'b00;
    localparam logic [1:0] GANO    = 2'b10;
    localparam logic [1:0] PERDIO  = 2'b01;

    localparam int unsigned TIMER_W       = 27;
    localparam int unsigned T_WLCM_DEF    = 54000000;
    localparam int unsigned T_WL_DEF      = 81000000;
    localparam int unsigned VIDAS_DEF     = 3;
    localparam int unsigned INV_TICKS_DEF = 2;
    localparam int unsigned N_PERS_DEF    = 4;

endpackage

// File: rtl/detector_flanco.sv
// Two-flop synchronizer followed by a rising-edge detector; pulso is high for one clk.
module detector_flanco (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulso
);

    logic s1_q, s2_q, prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign pulso = s2_q & ~prev_q;

endmodule

// File: rtl/control_juego.sv
// HEROE game sequencer: state, lives, hit detection and timed screens.
// Optional VIDA_EXTRA_EN: bonus pickups add a life during GAME.
module control_juego
    import heroe_pkg::*;
#(
    parameter int unsigned T_WLCM    = T_WLCM_DEF,
    parameter int unsigned T_WL      = T_WL_DEF,
    parameter int unsigned VIDAS     = VIDAS_DEF,
    parameter int unsigned INV_TICKS = INV_TICKS_DEF,
    parameter int unsigned N_PERS    = N_PERS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        btn_pausa,
    input  logic        btn_sel,
    input  logic        btn_power,
    input  logic        clk_obstaculos,
    input  logic [20:0] display_obs,
    input  logic [6:0]  heroe_seg,
    input  logic [1:0]  mundo,
    input  logic        bono_tomado,
    output logic [2:0]  presente,
    output logic [1:0]  W_or_L,
    output logic [2:0]  vidas,
    output logic [2:0]  personaje,
    output logic        golpe
);

    localparam logic [TIMER_W-1:0] WLCM_FIN  = TIMER_W'(T_WLCM - 1);
    localparam logic [TIMER_W-1:0] WL_FIN    = TIMER_W'(T_WL - 1);
    localparam logic [2:0]         VIDAS_INI = 3'(VIDAS);
    localparam logic [2:0]         INV_INI   = 3'(INV_TICKS);
    localparam logic [2:0]         PERS_MAX  = 3'(N_PERS - 1);

    logic ev_start, ev_pausa, ev_sel, ev_power, ev_tick, ev_bono;

    detector_flanco u_start (.clk(clk), .rst_n(rst_n), .din(btn_start),      .pulso(ev_start));
    detector_flanco u_pausa (.clk(clk), .rst_n(rst_n), .din(btn_pausa),      .pulso(ev_pausa));
    detector_flanco u_sel   (.clk(clk), .rst_n(rst_n), .din(btn_sel),        .pulso(ev_sel));
    detector_flanco u_power (.clk(clk), .rst_n(rst_n), .din(btn_power),      .pulso(ev_power));
    detector_flanco u_tick  (.clk(clk), .rst_n(rst_n), .din(clk_obstaculos), .pulso(ev_tick));

    estado_t            estado_q;
    logic [1:0]         wl_q;
    logic [2:0]         vidas_q, pers_q, inv_q;
    logic               golpe_q;
    logic [TIMER_W-1:0] timer_q, timer_inc;

    logic       choque, acepta;
    logic [2:0] inv_d, vidas_nueva;

`ifdef VIDA_EXTRA_EN
    detector_flanco u_bono (.clk(clk), .rst_n(rst_n), .din(bono_tomado), .pulso(ev_bono));
    logic unused_obs;
    assign unused_obs = ^display_obs[20:7];
`else
    assign ev_bono = 1'b0;
    logic unused_obs;
    assign unused_obs = ^{display_obs[20:7], bono_tomado, ev_bono};
`endif

    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    assign choque    = (display_obs[6:0] & heroe_seg) != 7'd0;
    // Invulnerability window suppresses the collision check entirely.
    assign acepta    = ev_tick && (inv_q == 3'd0) && choque && (vidas_q != 3'd0);

    always_comb begin
        inv_d = inv_q;
        if (ev_tick) begin
            if (inv_q != 3'd0) begin
                inv_d = inv_q - 3'd1;
            end else if (acepta) begin
                inv_d = INV_INI;
            end
        end
    end

    always_comb begin
        vidas_nueva = vidas_q;
`ifdef VIDA_EXTRA_EN
        // A same-cycle hit and bonus cancel out.
        if (acepta && !ev_bono) begin
            vidas_nueva = vidas_q - 3'd1;
        end else if (!acepta && ev_bono && vidas_q != 3'd7) begin
            vidas_nueva = vidas_q + 3'd1;
        end
`else
        if (acepta) begin
            vidas_nueva = vidas_q - 3'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OFF;
            wl_q     <= JUGANDO;
            vidas_q  <= VIDAS_INI;
            pers_q   <= 3'd0;
            inv_q    <= 3'd0;
            golpe_q  <= 1'b0;
            timer_q  <= '0;
        end else begin
            golpe_q <= 1'b0;
            timer_q <= timer_inc;
            if (ev_power) begin
                estado_q <= (estado_q == OFF) ? WLCM : OFF;
                wl_q     <= JUGANDO;
                timer_q  <= '0;
            end else begin
                case (estado_q)
                    OFF: if (ev_start) begin
                        estado_q <= WLCM;
                        timer_q  <= '0;
                    end
                    WLCM: if (timer_q == WLCM_FIN) begin
                        estado_q <= CH;
                        timer_q  <= '0;
                    end
                    CH: if (ev_start) begin
                        estado_q <= GAME;
                        vidas_q  <= VIDAS_INI;
                        inv_q    <= 3'd0;
                        wl_q     <= JUGANDO;
                        timer_q  <= '0;
                    end else if (ev_sel) begin
                        pers_q <= (pers_q == PERS_MAX) ? 3'd0 : pers_q + 3'd1;
                    end
                    GAME: if (mundo == 2'd3) begin
                        estado_q <= WL;
                        wl_q     <= GANO;
                        timer_q  <= '0;
                    end else begin
                        vidas_q <= vidas_nueva;
                        inv_q   <= inv_d;
                        golpe_q <= acepta;
                        if (acepta && vidas_nueva == 3'd0) begin
                            estado_q <= WL;
                            wl_q     <= PERDIO;
                            timer_q  <= '0;
                        end else if (ev_pausa) begin
                            estado_q <= PA;
                            timer_q  <= '0;
                        end
                    end
                    PA: if (ev_pausa) begin
                        estado_q <= GAME;
                        timer_q  <= '0;
                    end
                    WL: if (timer_q == WL_FIN) begin
                        estado_q <= CH;
                        wl_q     <= JUGANDO;
                        vidas_q  <= VIDAS_INI;
                        timer_q  <= '0;
                    end
                    default: begin
                        estado_q <= OFF;
                        timer_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign presente  = estado_q;
    assign W_or_L    = wl_q;
    assign vidas     = vidas_q;
    assign personaje = pers_q;
    assign golpe     = golpe_q;

endmodule

// File: doc/control_juego.md
Name: control_juego

Overview:
- Top-level game sequencer for HEROE.
- Owns the game state register (`presente`) and the win/lose code (`W_or_L`) consumed by the obstacle generator.
- Detects hero/obstacle collisions on each obstacle tick, manages lives and timed screens (welcome, win/lose).
- Sits between debounced buttons, the obstacle generator (`display_obs`, `mundo`, `clk_obstaculos`) and the display/LED drivers.

Parameters:
- T_WLCM, 54000000, welcome-screen duration in clk cycles (2 s @ 27 MHz)
- T_WL, 81000000, win/lose-screen duration in clk cycles (3 s)
- VIDAS, 3, lives at game start (1..7)
- INV_TICKS, 2, obstacle ticks of invulnerability after a hit (0..7)
- N_PERS, 4, number of selectable characters (1..8)

Ports:
- clk  in  1  system clock, 27 MHz
- rst_n  in  1  asynchronous active-low reset
- btn_start  in  1  debounced level: start/confirm
- btn_pausa  in  1  debounced level: pause toggle
- btn_sel  in  1  debounced level: cycle character in CH
- btn_power  in  1  debounced level: power toggle
- clk_obstaculos  in  1  obstacle tick from generator; treated as a data level, synchronized
- display_obs  in  21  obstacle shift register from generator; only [6:0] (hero column) used
- heroe_seg  in  7  segment mask currently occupied by hero
- mundo  in  2  generator world index; 3 = game complete
- bono_tomado  in  1  bonus pickup level
- presente  out  3  game state code (OFF=0, WLCM=1, CH=2, GAME=3, WL=4, PA=5)
- W_or_L  out  2  00 playing, 10 win, 01 lose; 11 never driven
- vidas  out  3  remaining lives
- personaje  out  3  selected character 0..N_PERS-1
- golpe  out  1  one-cycle pulse on an accepted hit

Behaviour:
- **Reset values:**
  - presente=OFF, W_or_L=00, vidas=VIDAS, personaje=0, golpe=0
  - timer=0, inv counter=0, all edge detectors cleared
  - Reset mid-game aborts immediately; no pending event survives.
- **Input conditioning:**
  - All button inputs, clk_obstaculos and bono_tomado pass through 2-FF sync + rising-edge detect.
  - An "event" is a one-clk pulse; latency from the input edge is 3 clk.
  - All logic runs on clk; clk_obstaculos is never used as a clock.
- **btn_power event:**
  - From any state except OFF → OFF, W_or_L=00.
  - From OFF → WLCM. btn_start also leaves OFF → WLCM.
- **WLCM:** timer counts 0..T_WLCM-1; on terminal count → CH, timer cleared.
- **CH:**
  - btn_sel event: personaje wraps N_PERS-1 → 0.
  - btn_start event → GAME; vidas=VIDAS, inv=0, W_or_L=00.
- **GAME, on a tick event:**
  - If inv≠0 → inv−1, no collision check.
  - Else if (display_obs[6:0] & heroe_seg)≠0 → golpe=1, vidas−1, inv=INV_TICKS.
  - If that decrement reaches 0 → WL with W_or_L=01, same cycle.
- **GAME, other events:**
  - mundo==3 → WL, W_or_L=10. Win has priority over a same-cycle hit; the hit is ignored and vidas is unchanged.
  - btn_pausa event → PA. Pause loses to a same-cycle win/lose.
- **PA:**
  - Ticks and collisions are ignored.
  - btn_pausa event → GAME; vidas, inv and personaje are retained.
- **WL:**
  - W_or_L is held; timer counts to T_WL-1.
  - Then → CH with W_or_L=00 and vidas=VIDAS.
  - btn_start during WL is ignored.
- **Simultaneous events:** power beats everything. Otherwise priority is win > lose > pause > select.
- **Counters:**
  - Timer is 27 bits and saturates; it clears on every state change.
  - vidas never underflows.

Optional Feature:
- Macro: VIDA_EXTRA_EN
- **Defined:** a bono_tomado event in GAME increments vidas, saturating at 7. A bono event and a hit in the same cycle cancel out (net vidas unchanged; golpe still pulses; inv is still loaded).
- **Undefined:** bono_tomado is not synchronized or used; lives only decrease.

Decomposition:
- **Package heroe_pkg:**
  - state codes OFF/WLCM/CH/GAME/WL/PA (3-bit)
  - W_or_L codes JUGANDO=2'b00, GANO=2'b10, PERDIO=2'b01
  - default timing constants
- **Sub-module detector_flanco:** 2-FF synchronizer + rising-edge pulse with async active-low reset. Instantiated per conditioned input.

Test Plan:
- Reset, then btn_start pulse with T_WLCM=10 → presente OFF→WLCM at +3 clk → CH exactly 10 clk later; vidas=3, W_or_L=00.
- In CH, 5 btn_sel pulses with N_PERS=4 → personaje=1. Then btn_start → GAME.
- GAME, heroe_seg=7'h08, display_obs[6:0]=7'h08, 3 ticks with INV_TICKS=2 → one golpe pulse; vidas 3→2; ticks 2-3 ignored. Next overlapping tick → vidas=1.
- GAME with vidas=1, overlapping tick → vidas=0, presente=WL, W_or_L=01. After T_WL=20 clk → CH, W_or_L=00, vidas=3.
- GAME, mundo=3 and overlapping tick in the same cycle → WL, W_or_L=10, vidas unchanged, no golpe.
- GAME, btn_pausa → PA; 5 overlapping ticks → vidas unchanged. btn_pausa → GAME. btn_power during GAME → OFF. rst_n low mid-WL → all outputs at reset values.
